// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I data-memory access unit sitting between execute and a simple
// valid/ready data-memory port.  One operation is in flight at a time.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   reqValid/reqReady    op handshake from execute (ready only when idle)
//   isStore, funct3      op kind and RV32I width/sign code
//   addr, storeData      effective address and rs2 value
//   rdIdx                load destination register
//   flush                pipeline redirect, aborts the current op
//   memReqValid/Ready    data-memory request handshake
//   memAddr/We/ByteEn/Wdata  registered request payload
//   memRspValid/memRdata load response (never back-pressured)
//   wbValid/wbRdIdx/wbData   one-cycle load writeback
//   fault/faultAddr      one-cycle pulse for misaligned/illegal ops
//   busy                 unit is not idle
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            isStore,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] storeData,
    input  logic [4:0]      rdIdx,
    input  logic            flush,
    output logic            memReqValid,
    input  logic            memReqReady,
    output logic [XLEN-1:0] memAddr,
    output logic            memWe,
    output logic [3:0]      memByteEn,
    output logic [XLEN-1:0] memWdata,
    input  logic            memRspValid,
    input  logic [XLEN-1:0] memRdata,
    output logic            wbValid,
    output logic [4:0]      wbRdIdx,
    output logic [XLEN-1:0] wbData,
    output logic            fault,
    output logic [XLEN-1:0] faultAddr,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RSP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Byte-lane mask for an access of the given size at the given lane.
    function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so any lane the byte enables pick holds it.
    function automatic logic [XLEN-1:0] wdata_f(input logic [1:0] size, input logic [XLEN-1:0] sd);
        logic [XLEN-1:0] wd;
        case (size)
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Pull the addressed lane down to bit 0 and sign/zero extend it.
    function automatic logic [XLEN-1:0] load_ext_f(input logic [2:0] f3, input logic [1:0] lane,
                                                   input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    state_t          state_r, state_nxt_s;

    logic [2:0]      op_f3_r, op_f3_nxt_s;
    logic [1:0]      op_lane_r, op_lane_nxt_s;
    logic [4:0]      op_rd_r, op_rd_nxt_s;

    logic            mem_req_valid_r, mem_req_valid_nxt_s;
    logic [XLEN-1:0] mem_addr_r, mem_addr_nxt_s;
    logic            mem_we_r, mem_we_nxt_s;
    logic [3:0]      mem_byte_en_r, mem_byte_en_nxt_s;
    logic [XLEN-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic            wb_valid_r, wb_valid_nxt_s;
    logic [4:0]      wb_rd_r, wb_rd_nxt_s;
    logic [XLEN-1:0] wb_data_r, wb_data_nxt_s;
    logic            fault_r, fault_nxt_s;
    logic [XLEN-1:0] fault_addr_r, fault_addr_nxt_s;

    logic            cap_s;
    logic            illegal_s;
    logic            misalign_s;
    logic            bad_op_s;

    // Flush in IDLE suppresses capture for that cycle.
    assign cap_s      = reqValid && (state_r == ST_IDLE) && !flush;
    assign illegal_s  = isStore ? (funct3 >= 3'd3)
                                : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    assign misalign_s = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign bad_op_s   = illegal_s || misalign_s;

    assign reqReady    = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign memReqValid = mem_req_valid_r;
    assign memAddr     = mem_addr_r;
    assign memWe       = mem_we_r;
    assign memByteEn   = mem_byte_en_r;
    assign memWdata    = mem_wdata_r;
    assign wbValid     = wb_valid_r;
    assign wbRdIdx     = wb_rd_r;
    assign wbData      = wb_data_r;
    assign fault       = fault_r;
    assign faultAddr   = fault_addr_r;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cap_s && !bad_op_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Acceptance wins over a coincident flush: the memory already has the op.
                if (memReqReady) begin
                    if (mem_we_r) begin
                        state_nxt_s = ST_IDLE;
                    end else if (flush) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RSP;
                    end
                end else if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RSP: begin
                // A response arriving with the flush is consumed here, so no drain is needed.
                if (memRspValid) begin
                    state_nxt_s = ST_IDLE;
                end else if (flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            ST_DRAIN: begin
                if (memRspValid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and captured op fields.
    always_comb begin
        op_f3_nxt_s         = op_f3_r;
        op_lane_nxt_s       = op_lane_r;
        op_rd_nxt_s         = op_rd_r;
        mem_req_valid_nxt_s = mem_req_valid_r;
        mem_addr_nxt_s      = mem_addr_r;
        mem_we_nxt_s        = mem_we_r;
        mem_byte_en_nxt_s   = mem_byte_en_r;
        mem_wdata_nxt_s     = mem_wdata_r;
        wb_valid_nxt_s      = 1'b0;
        wb_rd_nxt_s         = wb_rd_r;
        wb_data_nxt_s       = wb_data_r;
        fault_nxt_s         = 1'b0;
        fault_addr_nxt_s    = fault_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (cap_s && bad_op_s) begin
                    fault_nxt_s      = 1'b1;
                    fault_addr_nxt_s = addr;
                end else if (cap_s) begin
                    op_f3_nxt_s         = funct3;
                    op_lane_nxt_s       = addr[1:0];
                    op_rd_nxt_s         = rdIdx;
                    mem_req_valid_nxt_s = 1'b1;
                    mem_addr_nxt_s      = {addr[XLEN-1:2], 2'b00};
                    mem_we_nxt_s        = isStore;
                    mem_byte_en_nxt_s   = byte_en_f(funct3[1:0], addr[1:0]);
                    mem_wdata_nxt_s     = wdata_f(funct3[1:0], storeData);
                end else begin
                    mem_req_valid_nxt_s = 1'b0;
                end
            end
            ST_REQ: begin
                // Payload holds while stalled; only valid drops on accept or abort.
                if (memReqReady || flush) begin
                    mem_req_valid_nxt_s = 1'b0;
                end else begin
                    mem_req_valid_nxt_s = 1'b1;
                end
            end
            ST_RSP: begin
                if (memRspValid) begin
                    wb_data_nxt_s  = load_ext_f(op_f3_r, op_lane_r, memRdata);
                    wb_rd_nxt_s    = op_rd_r;
                    wb_valid_nxt_s = !flush && (op_rd_r != 5'd0);
                end else begin
                    wb_valid_nxt_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                wb_valid_nxt_s = 1'b0;
            end
            default: begin
                mem_req_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output and op-field registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_f3_r         <= 3'd0;
            op_lane_r       <= 2'd0;
            op_rd_r         <= 5'd0;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= {XLEN{1'b0}};
            mem_we_r        <= 1'b0;
            mem_byte_en_r   <= 4'd0;
            mem_wdata_r     <= {XLEN{1'b0}};
            wb_valid_r      <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_data_r       <= {XLEN{1'b0}};
            fault_r         <= 1'b0;
            fault_addr_r    <= {XLEN{1'b0}};
        end else begin
            op_f3_r         <= op_f3_nxt_s;
            op_lane_r       <= op_lane_nxt_s;
            op_rd_r         <= op_rd_nxt_s;
            mem_req_valid_r <= mem_req_valid_nxt_s;
            mem_addr_r      <= mem_addr_nxt_s;
            mem_we_r        <= mem_we_nxt_s;
            mem_byte_en_r   <= mem_byte_en_nxt_s;
            mem_wdata_r     <= mem_wdata_nxt_s;
            wb_valid_r      <= wb_valid_nxt_s;
            wb_rd_r         <= wb_rd_nxt_s;
            wb_data_r       <= wb_data_nxt_s;
            fault_r         <= fault_nxt_s;
            fault_addr_r    <= fault_addr_nxt_s;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of directed ops with
// hand-computed expectations, followed by hand-written multi-cycle sequences
// for stalls, flushes, response ordering and mid-transaction reset.
module tb_load_store_unit;

    logic        clk;
    logic        rstn;
    logic        reqValid;
    logic        reqReady;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [4:0]  rdIdx;
    logic        flush;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memAddr;
    logic        memWe;
    logic [3:0]  memByteEn;
    logic [31:0] memWdata;
    logic        memRspValid;
    logic [31:0] memRdata;
    logic        wbValid;
    logic [4:0]  wbRdIdx;
    logic [31:0] wbData;
    logic        fault;
    logic [31:0] faultAddr;
    logic        busy;

    int n_chk;
    int n_fail;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn),
        .reqValid(reqValid), .reqReady(reqReady),
        .isStore(isStore), .funct3(funct3), .addr(addr),
        .storeData(storeData), .rdIdx(rdIdx), .flush(flush),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memAddr(memAddr), .memWe(memWe), .memByteEn(memByteEn),
        .memWdata(memWdata), .memRspValid(memRspValid), .memRdata(memRdata),
        .wbValid(wbValid), .wbRdIdx(wbRdIdx), .wbData(wbData),
        .fault(fault), .faultAddr(faultAddr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        exp_fault;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [4:0] rd);
        reqValid  = 1'b1;
        isStore   = st;
        funct3    = f3;
        addr      = a;
        storeData = sd;
        rdIdx     = rd;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk($sformatf("v%0d_ready_before", idx), {31'd0, reqReady}, 32'd1);
        present(v.is_store, v.f3, v.addr, v.sd, v.rd);
        tick();
        reqValid = 1'b0;
        if (v.exp_fault) begin
            chk($sformatf("v%0d_fault", idx), {31'd0, fault}, 32'd1);
            chk($sformatf("v%0d_fault_addr", idx), faultAddr, v.addr);
            chk($sformatf("v%0d_no_memreq", idx), {31'd0, memReqValid}, 32'd0);
            chk($sformatf("v%0d_ready_kept", idx), {31'd0, reqReady}, 32'd1);
            tick();
            chk($sformatf("v%0d_fault_pulse", idx), {31'd0, fault}, 32'd0);
            chk($sformatf("v%0d_no_memreq2", idx), {31'd0, memReqValid}, 32'd0);
        end else begin
            chk($sformatf("v%0d_memreq", idx), {31'd0, memReqValid}, 32'd1);
            chk($sformatf("v%0d_maddr", idx), memAddr, v.exp_maddr);
            chk($sformatf("v%0d_be", idx), {28'd0, memByteEn}, {28'd0, v.exp_be});
            chk($sformatf("v%0d_we", idx), {31'd0, memWe}, {31'd0, v.is_store});
            chk($sformatf("v%0d_no_fault", idx), {31'd0, fault}, 32'd0);
            if (v.is_store) begin
                chk($sformatf("v%0d_wdata", idx), memWdata, v.exp_wdata);
            end
            memReqReady = 1'b1;
            tick();
            memReqReady = 1'b0;
            chk($sformatf("v%0d_memreq_drop", idx), {31'd0, memReqValid}, 32'd0);
            if (v.is_store) begin
                chk($sformatf("v%0d_st_idle", idx), {31'd0, reqReady}, 32'd1);
                chk($sformatf("v%0d_st_no_wb", idx), {31'd0, wbValid}, 32'd0);
            end else begin
                chk($sformatf("v%0d_ld_busy", idx), {31'd0, busy}, 32'd1);
                memRspValid = 1'b1;
                memRdata    = v.rdata;
                tick();
                memRspValid = 1'b0;
                memRdata    = 32'hDEAD_0000;
                chk($sformatf("v%0d_wb_valid", idx), {31'd0, wbValid}, {31'd0, v.exp_wb});
                if (v.exp_wb) begin
                    chk($sformatf("v%0d_wb_data", idx), wbData, v.exp_wb_data);
                    chk($sformatf("v%0d_wb_rd", idx), {27'd0, wbRdIdx}, {27'd0, v.rd});
                end
                chk($sformatf("v%0d_no_fault_wb", idx), {31'd0, fault}, 32'd0);
                tick();
                chk($sformatf("v%0d_wb_pulse", idx), {31'd0, wbValid}, 32'd0);
                chk($sformatf("v%0d_ld_idle", idx), {31'd0, reqReady}, 32'd1);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_memreq"}, {31'd0, memReqValid}, 32'd0);
        chk({tag, "_we"}, {31'd0, memWe}, 32'd0);
        chk({tag, "_be"}, {28'd0, memByteEn}, 32'd0);
        chk({tag, "_wdata"}, memWdata, 32'd0);
        chk({tag, "_maddr"}, memAddr, 32'd0);
        chk({tag, "_wbv"}, {31'd0, wbValid}, 32'd0);
        chk({tag, "_wbrd"}, {27'd0, wbRdIdx}, 32'd0);
        chk({tag, "_wbdata"}, wbData, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_faddr"}, faultAddr, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, reqReady}, 32'd1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        //          st    f3      addr          sd            rdata         rd     flt   maddr         be       wdata         wb    wb_data
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 5'd5,  1'b0, 32'h0000_1000, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'b100, 32'h0000_1001, 32'h0,        32'h80FF_1234, 5'd6,  1'b0, 32'h0000_1000, 4'b0010, 32'h0,        1'b1, 32'h0000_0012};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h80FF_1234, 5'd7,  1'b0, 32'h0000_1000, 4'b1100, 32'h0,        1'b1, 32'hFFFF_80FF};
        vecs[3]  = '{1'b0, 3'b101, 32'h0000_1000, 32'h0,        32'h80FF_9234, 5'd8,  1'b0, 32'h0000_1000, 4'b0011, 32'h0,        1'b1, 32'h0000_9234};
        vecs[4]  = '{1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 5'd31, 1'b0, 32'h0000_1004, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_1008, 32'h0,        32'h1234_5678, 5'd0,  1'b0, 32'h0000_1008, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'h0,        5'd1,  1'b0, 32'h0000_2000, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        5'd1,  1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 32'h0,        5'd1,  1'b0, 32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        5'd3,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_3003, 32'h0,        32'h0,        5'd3,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,        5'd3,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_3004, 32'h0,        32'h0,        5'd3,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b1, 3'b010, 32'h0000_2002, 32'h0,        32'h0,        5'd3,  1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_5006, 32'h0,        32'h007F_0000, 5'd9,  1'b0, 32'h0000_5004, 4'b0100, 32'h0,        1'b1, 32'h0000_007F};

        rstn = 1'b0;
        reqValid = 1'b0; isStore = 1'b0; funct3 = 3'd0; addr = 32'd0;
        storeData = 32'd0; rdIdx = 5'd0; flush = 1'b0;
        memReqReady = 1'b0; memRspValid = 1'b0; memRdata = 32'd0;
        #2;
        chk_all_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end

        // Store held off by memory for three cycles: payload must not move.
        present(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd4);
        tick();
        reqValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", {31'd0, memReqValid}, 32'd1);
            chk("stall_wdata", memWdata, 32'hABCD_ABCD);
            chk("stall_be", {28'd0, memByteEn}, 32'h0000_000C);
            chk("stall_we", {31'd0, memWe}, 32'd1);
            chk("stall_no_wb", {31'd0, wbValid}, 32'd0);
            tick();
        end
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        chk("stall_done_idle", {31'd0, reqReady}, 32'd1);
        chk("stall_done_no_wb", {31'd0, wbValid}, 32'd0);

        // Flush while waiting for a load response: drain it silently.
        present(1'b0, 3'b101, 32'h0000_4000, 32'h0, 5'd10);
        tick();
        reqValid = 1'b0;
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drain_busy", {31'd0, busy}, 32'd1);
            chk("drain_not_ready", {31'd0, reqReady}, 32'd0);
            chk("drain_no_wb", {31'd0, wbValid}, 32'd0);
            tick();
        end
        memRspValid = 1'b1;
        memRdata = 32'hFFFF_8001;
        tick();
        memRspValid = 1'b0;
        chk("drain_rsp_no_wb", {31'd0, wbValid}, 32'd0);
        chk("drain_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("drain_no_wb_late", {31'd0, wbValid}, 32'd0);

        // Flush coincident with load acceptance still needs a drain.
        present(1'b0, 3'b010, 32'h0000_4100, 32'h0, 5'd11);
        tick();
        reqValid = 1'b0;
        memReqReady = 1'b1;
        flush = 1'b1;
        tick();
        memReqReady = 1'b0;
        flush = 1'b0;
        chk("flacc_valid_drop", {31'd0, memReqValid}, 32'd0);
        chk("flacc_busy", {31'd0, busy}, 32'd1);
        memRspValid = 1'b1;
        memRdata = 32'h1111_2222;
        tick();
        memRspValid = 1'b0;
        chk("flacc_no_wb", {31'd0, wbValid}, 32'd0);
        chk("flacc_idle", {31'd0, busy}, 32'd0);

        // Flush before acceptance withdraws the request.
        present(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd12);
        tick();
        reqValid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flreq_valid_drop", {31'd0, memReqValid}, 32'd0);
        chk("flreq_idle", {31'd0, reqReady}, 32'd1);

        // Flush in IDLE blocks capture.
        present(1'b0, 3'b010, 32'h0000_6004, 32'h0, 5'd12);
        flush = 1'b1;
        tick();
        reqValid = 1'b0;
        flush = 1'b0;
        chk("flidle_no_req", {31'd0, memReqValid}, 32'd0);
        chk("flidle_not_busy", {31'd0, busy}, 32'd0);
        chk("flidle_no_fault", {31'd0, fault}, 32'd0);

        // A response in the acceptance cycle is not the load's response.
        present(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd13);
        tick();
        reqValid = 1'b0;
        memReqReady = 1'b1;
        memRspValid = 1'b1;
        memRdata = 32'hBAD0_BAD0;
        tick();
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        chk("early_rsp_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("early_rsp_no_wb", {31'd0, wbValid}, 32'd0);
        memRspValid = 1'b1;
        memRdata = 32'h0123_4567;
        tick();
        memRspValid = 1'b0;
        chk("early_rsp_wb", {31'd0, wbValid}, 32'd1);
        chk("early_rsp_data", wbData, 32'h0123_4567);
        chk("early_rsp_rd", {27'd0, wbRdIdx}, 32'd13);

        // Reset while waiting for a load response.
        present(1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd14);
        tick();
        reqValid = 1'b0;
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        chk("rstmid_in_rsp", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk_all_zero("rstmid");
        tick();
        rstn = 1'b1;
        memRspValid = 1'b1;
        memRdata = 32'h5555_AAAA;
        tick();
        memRspValid = 1'b0;
        chk("rstmid_late_no_wb", {31'd0, wbValid}, 32'd0);
        chk("rstmid_late_idle", {31'd0, busy}, 32'd0);
        run_vec(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 reqValid  in  1  execute stage presents a memory op.
REQ-005 reqReady  out  1  unit can accept an op.
REQ-006 isStore  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RV32I width/sign code.
REQ-008 addr  in  32  effective address (ALU adder result).
REQ-009 storeData  in  32  rs2 value.
REQ-010 rdIdx  in  5  load destination register.
REQ-011 flush  in  1  abort the current op (pipeline redirect).
REQ-012 memReqValid / memReqReady  out / in  1 / 1  data-memory request handshake.
REQ-013 memAddr  out  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-014 memWe  out  1  write enable.
REQ-015 memByteEn  out  4  byte lanes.
REQ-016 memWdata  out  32  lane-replicated store data.
REQ-017 memRspValid / memRdata  in / in  1 / 32  load response; no backpressure on it.
REQ-018 wbValid / wbRdIdx / wbData  out / out / out  1 / 5 / 32  load writeback, 1-cycle pulse.
REQ-019 fault / faultAddr  out / out  1 / 32  misaligned or illegal-funct3 pulse and the offending address.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM shall have exactly four states: IDLE, REQ, RSP and DRAIN.
REQ-022 reqReady shall be 1 only in IDLE; the op is captured on reqValid && reqReady.
REQ-023 Capture shall classify the op as follows.
- Illegal: loads with funct3 011/110/111; stores with funct3 >= 011.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Illegal or misaligned: stay in IDLE, issue no memory request, pulse fault for the next cycle with faultAddr = addr.
- Otherwise: go to REQ.
REQ-024 memReqValid, memAddr, memWe, memByteEn and memWdata shall be registered.
- They shall be valid starting the cycle after capture.
- They shall stay stable while memReqValid && !memReqReady.
REQ-025 Byte enables shall be:
- SB: 4'b0001 << addr[1:0].
- SH: 4'b0011 << addr[1:0].
- SW: 4'b1111.
- Loads: same pattern, with memWe = 0.
REQ-026 memWdata shall be {4{sd[7:0]}} for SB, {2{sd[15:0]}} for SH, and sd for SW.
REQ-027 In REQ, on memReqReady the unit shall go to IDLE for a store and to RSP for a load; memReqValid shall drop in the following cycle.
REQ-028 In RSP, on memRspValid the unit shall extract and extend the load data from the lane selected by addr[1:0].
- LB / LH: sign-extend.
- LBU / LHU: zero-extend.
- LW: pass through.
- The unit shall register the result into wbData, pulse wbValid the next cycle, and return to IDLE.
REQ-029 wbValid shall not assert when rdIdx = 0; the access shall still be performed.
REQ-030 Minimum latency from capture:
- Store: memReqValid at cycle +1, and with zero-wait memory the unit returns to IDLE at +2.
- Load: wbValid at cycle N+1, where N is the memRspValid cycle.
REQ-031 A memRspValid in the same cycle as memReqReady shall be ignored; a response is only accepted in RSP.
REQ-032 Flush behaviour depends on the state:
- IDLE: no effect, and it blocks capture that cycle.
- REQ before acceptance: drop memReqValid next cycle and go to IDLE.
- Flush coincident with memReqReady: treated as accepted. A store completes and the unit goes to IDLE; a load goes to DRAIN.
- RSP: go to DRAIN.
REQ-033 DRAIN shall wait for memRspValid, discard the data with no wbValid, and then return to IDLE.
REQ-034 memRspValid shall be ignored in IDLE and REQ.
REQ-035 fault and wbValid shall never both be high.

Reset
REQ-036 On rstn low the state shall go to IDLE asynchronously, and these outputs shall be 0: memReqValid, memWe, memByteEn, memWdata, memAddr, wbValid, wbRdIdx, wbData, fault, faultAddr and busy.
REQ-037 reqReady shall equal 1 during reset.
REQ-038 Reset mid-transaction shall abandon the transaction without writeback, and a late memRspValid after reset shall be ignored.

Verification
REQ-039 LB, addr 0x1003, memRdata 0x80FF_1234 -> memAddr 0x1000, memByteEn 4'b1000, wbData 0xFFFF_FF80, wbValid one cycle.
REQ-040 SH, addr 0x2002, storeData 0x0000_ABCD, memReqReady held low 3 cycles -> memWdata 0xABCD_ABCD and memByteEn 4'b1100 held stable, memWe 1, no wbValid.
REQ-041 LW, addr 0x3001 -> fault 1 for one cycle, faultAddr 0x3001, memReqValid never asserts, reqReady stays 1.
REQ-042 LHU, addr 0x4000, flush in RSP, then memRspValid with 0xFFFF_8001 -> no wbValid, busy until the response arrives, then back to IDLE.
REQ-043 LW accepted, rstn pulsed low in RSP, then memRspValid -> all outputs 0, no wbValid, unit accepts a new op.
